seg7_disp_sched: RTL and testbench
==================================

Name: seg7_disp_sched

Overview:
- Time-shares one 4-digit seven-segment decimal display among NREQ requesters, e.g. time-of-day, alarm setting and stopwatch.
- Each requester offers a 16-bit BCD value. The block grants the display to one requester at a time, round-robin, with a guaranteed minimum dwell.
- It drives the 16-bit value input and a blank control into the existing display driver.
- It sits between the clock/alarm datapath and the display driver.

Parameters:
- NREQ, 3, number of requesters (2..8).
- HOLD_CYC, 1000, minimum clk cycles a grant is held before re-arbitration (>=2).
- BLINK_DIV, 500, half-period in clk cycles of the blink toggle (used only with SEG7_BLINK_EN).

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- clr  in  1  synchronous active-high reset.
- req  in  NREQ  per-requester display request, level-sensitive.
- val  in  NREQ*16  packed BCD values; requester i occupies bits [16*i+15:16*i].
- blink_req  in  NREQ  requester i asks for a blinking display (effective only with SEG7_BLINK_EN).
- grant  out  NREQ  one-hot current owner; all zero when idle.
- x  out  16  value to the display driver.
- blank  out  1  high = display dark.
- busy  out  1  high while any grant is active.

Behaviour:
- Reset: when clr=1 at a clock edge:
  - grant=0, x=16'h0000, blank=1, busy=0.
  - State IDLE; dwell counter cnt=0; round-robin pointer ptr=0 (requester 0 has highest priority next).
- States:
  - IDLE: no owner. If req!=0, select the first requester with req set, searching from ptr upward with wrap-around. Go to SHOW; grant=onehot(sel) and busy=1 are registered on the same edge; cnt=0.
  - SHOW: an owner holds the display.
    - cnt increments each cycle and saturates at HOLD_CYC-1.
    - x <= val[owner] every cycle, so x lags val by 1 clk.
    - blank <= 0, unless modified by the optional blink feature.
- Dwell end (cnt==HOLD_CYC-1), evaluated every cycle while in SHOW:
  - Another requester j != owner has req=1: hand over to the next requester after the owner in round-robin order. Set ptr=owner+1 mod NREQ, grant=onehot(j), cnt=0. There are no idle cycles between owners.
  - Otherwise, if the owner's req=1: keep the grant and keep cnt saturated.
  - Otherwise (no requests): go to IDLE. Set grant=0, busy=0, blank=1, ptr=owner+1 mod NREQ. x holds its last value.
- Owner deasserts req before dwell end: the grant is still held until dwell end (no flicker). x keeps tracking val[owner].
- Simultaneous requests from IDLE: the lowest index at or after ptr wins.
- grant is always one-hot or zero; x never mixes two requesters' values.
- Reset mid-SHOW: the reset response above is immediate (next edge), regardless of cnt.
- Counter widths: cnt is $clog2(HOLD_CYC) bits; the pointer is $clog2(NREQ) bits. Wrap is computed modulo NREQ, not modulo 2^width.

Optional Feature:
- SEG7_BLINK_EN defined:
  - A free-running blink counter (width $clog2(BLINK_DIV)) toggles phase every BLINK_DIV cycles. It is reset to 0 with phase=0 by clr.
  - In SHOW, when blink_req[owner]=1, blank <= phase.
  - The counter runs continuously; it is not restarted on a grant change.
- SEG7_BLINK_EN undefined:
  - blink_req is ignored; no blink counter exists.
  - blank = 1 in IDLE, 0 in SHOW.

Decomposition:
- Shared package seg7_pkg:
  - State encoding typedef (IDLE, SHOW).
  - Constants SEG7_DIGITS=4 and SEG7_VAL_W=16.
  - BCD blank code constant 16'h0000.
- One sub-module, seg7_rr_pick: combinational round-robin selector. Inputs: req, ptr, exclude_idx, exclude_en. Outputs: sel index, valid.
- All state and counters live in seg7_disp_sched.

Test Plan:
All scenarios use NREQ=3, HOLD_CYC=8, BLINK_DIV=4.
1. Reset: assert clr 2 cycles with random req/val -> grant=000, x=0000, blank=1, busy=0 on the first edge after clr.
2. Single requester: req=001, val0=16'h1234 -> grant=001 one cycle later, x=1234 the following cycle, blank=0. Change val0 to 16'h1235 -> x follows 1 cycle later.
3. Contention: req=111 from IDLE, ptr=0 -> grant sequence 001, 010, 100, 001, each held exactly 8 cycles with no gap. x shows val0/val1/val2 accordingly.
4. Early release: owner 1 drops req after 3 cycles, others idle -> grant=010 kept until cycle 8, then grant=000, busy=0, blank=1. Next req=011 grants requester 0 (ptr=2 wraps to 0).
5. Reset mid-dwell: clr at cnt=4 while grant=100 -> all outputs at reset values next edge; after clr release with req=100, dwell restarts at cnt=0.
6. Blink (SEG7_BLINK_EN): owner 0 with blink_req=001 -> blank toggles every 4 cycles while granted. Without the macro, blank stays 0 throughout SHOW.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared types and constants for the seven-segment display scheduler.
package seg7_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SHOW = 1'b1
  } seg7_state_e;

  localparam int SEG7_DIGITS = 4;
  localparam int SEG7_VAL_W  = 16;
  localparam logic [15:0] SEG7_BLANK_CODE = 16'h0000;

  // Round-robin successor of idx among n requesters (wraps at n, not at a power of two).
  function automatic int seg7_wrap_inc(input int idx, input int n);
    return ((idx + 1) >= n) ? 0 : (idx + 1);
  endfunction

endpackage

// File: rtl/seg7_rr_pick.sv
// Combinational round-robin selector: first set request at or after ptr_i,
// wrapping modulo NREQ, optionally skipping one excluded index.
module seg7_rr_pick
  import seg7_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int PW   = 2
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [PW-1:0]   ptr_i,
  input  logic [PW-1:0]   exclude_idx_i,
  input  logic            exclude_en_i,
  output logic [PW-1:0]   sel_o,
  output logic            valid_o
);

  // Scan from farthest to nearest offset so the nearest hit overwrites.
  always_comb begin
    sel_o   = PW'(0);
    valid_o = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      int  idx;
      logic hit;
      idx     = (int'(ptr_i) + k) % NREQ;
      hit     = req_i[idx] & ~(exclude_en_i & (int'(exclude_idx_i) == idx));
      sel_o   = hit ? PW'(idx) : sel_o;
      valid_o = valid_o | hit;
    end
  end

endmodule

// File: rtl/seg7_disp_sched.sv
// Round-robin time-sharing of one 4-digit BCD display with a minimum dwell per owner.
// Optional blinking display is enabled by defining SEG7_BLINK_EN.
module seg7_disp_sched
  import seg7_pkg::*;
#(
  parameter int NREQ      = 3,
  parameter int HOLD_CYC  = 1000,
  parameter int BLINK_DIV = 500
) (
  input  logic                       clk,
  input  logic                       clr,
  input  logic [NREQ-1:0]            req,
  input  logic [NREQ*SEG7_VAL_W-1:0] val,
  input  logic [NREQ-1:0]            blink_req,
  output logic [NREQ-1:0]            grant,
  output logic [SEG7_VAL_W-1:0]      x,
  output logic                       blank,
  output logic                       busy
);

  localparam int PW = $clog2(NREQ);
  localparam int CW = $clog2(HOLD_CYC);
  localparam logic [CW-1:0] CNT_MAX = CW'(HOLD_CYC - 1);

  seg7_state_e           state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [PW-1:0]         ptr_q, ptr_d;
  logic [PW-1:0]         owner_q, owner_d;
  logic [NREQ-1:0]       grant_q, grant_d;
  logic [SEG7_VAL_W-1:0] x_q, x_d;
  logic                  blank_q, blank_d;
  logic                  busy_q, busy_d;

  logic [SEG7_VAL_W-1:0] owner_val_s;
  logic                  owner_req_s;
  logic                  owner_blink_s;
  logic [PW-1:0]         nxt_owner_s;
  logic [PW-1:0]         pick_ptr_s;
  logic                  pick_excl_en_s;
  logic [PW-1:0]         pick_sel_s;
  logic                  pick_valid_s;
  logic                  show_blank_s;

  function automatic logic [NREQ-1:0] onehot(input logic [PW-1:0] idx);
    logic [NREQ-1:0] v;
    for (int i = 0; i < NREQ; i++) begin
      v[i] = (idx == PW'(i));
    end
    return v;
  endfunction

  // Per-owner views of the request, value and blink inputs.
  always_comb begin
    owner_val_s   = SEG7_BLANK_CODE;
    owner_req_s   = 1'b0;
    owner_blink_s = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      owner_val_s   = (owner_q == PW'(i)) ? val[i*SEG7_VAL_W +: SEG7_VAL_W] : owner_val_s;
      owner_req_s   = (owner_q == PW'(i)) ? req[i] : owner_req_s;
      owner_blink_s = (owner_q == PW'(i)) ? blink_req[i] : owner_blink_s;
    end
  end

  assign nxt_owner_s    = PW'(seg7_wrap_inc(int'(owner_q), NREQ));
  assign pick_ptr_s     = (state_q == ST_SHOW) ? nxt_owner_s : ptr_q;
  assign pick_excl_en_s = (state_q == ST_SHOW);

  seg7_rr_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_pick (
    .req_i         (req),
    .ptr_i         (pick_ptr_s),
    .exclude_idx_i (owner_q),
    .exclude_en_i  (pick_excl_en_s),
    .sel_o         (pick_sel_s),
    .valid_o       (pick_valid_s)
  );

`ifdef SEG7_BLINK_EN
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_DIV - 1);

  logic [BW-1:0] bcnt_q;
  logic          phase_q;

  // Free-running blink phase; never restarted by grant changes.
  always_ff @(posedge clk) begin
    if (clr) begin
      bcnt_q  <= BW'(0);
      phase_q <= 1'b0;
    end else if (bcnt_q == BLINK_MAX) begin
      bcnt_q  <= BW'(0);
      phase_q <= ~phase_q;
    end else begin
      bcnt_q  <= bcnt_q + BW'(1);
      phase_q <= phase_q;
    end
  end

  assign show_blank_s = owner_blink_s ? phase_q : 1'b0;
`else
  logic unused_blink_s;
  assign unused_blink_s = ^{blink_req, owner_blink_s, (BLINK_DIV > 0)};
  assign show_blank_s   = 1'b0;
`endif

  // Scheduler next state: arbitration, dwell counting and hand-over.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    grant_d = grant_q;
    x_d     = x_q;
    blank_d = blank_q;
    busy_d  = busy_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid_s) begin
          state_d = ST_SHOW;
          owner_d = pick_sel_s;
          grant_d = onehot(pick_sel_s);
          busy_d  = 1'b1;
          cnt_d   = CW'(0);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHOW: begin
        x_d     = owner_val_s;
        blank_d = show_blank_s;
        if (cnt_q == CNT_MAX) begin
          if (pick_valid_s) begin
            owner_d = pick_sel_s;
            grant_d = onehot(pick_sel_s);
            cnt_d   = CW'(0);
            ptr_d   = nxt_owner_s;
          end else if (owner_req_s) begin
            cnt_d = CNT_MAX;
          end else begin
            // Nobody wants the display: go dark but leave x at its last value.
            state_d = ST_IDLE;
            grant_d = {NREQ{1'b0}};
            busy_d  = 1'b0;
            blank_d = 1'b1;
            ptr_d   = nxt_owner_s;
            cnt_d   = CW'(0);
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = {NREQ{1'b0}};
        busy_d  = 1'b0;
        blank_d = 1'b1;
        cnt_d   = CW'(0);
      end
    endcase
  end

  // State and output registers with synchronous clear.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= ST_IDLE;
      cnt_q   <= CW'(0);
      ptr_q   <= PW'(0);
      owner_q <= PW'(0);
      grant_q <= {NREQ{1'b0}};
      x_q     <= SEG7_BLANK_CODE;
      blank_q <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      grant_q <= grant_d;
      x_q     <= x_d;
      blank_q <= blank_d;
      busy_q  <= busy_d;
    end
  end

  assign grant = grant_q;
  assign x     = x_q;
  assign blank = blank_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_seg7_disp_sched.sv
// Self-checking bench for seg7_disp_sched (NREQ=3, HOLD_CYC=8, BLINK_DIV=4).
module tb_seg7_disp_sched;

  localparam int NREQ = 3;
  localparam int HOLD = 8;
  localparam int BDIV = 4;
`ifdef SEG7_BLINK_EN
  localparam bit BLINK_ON = 1'b1;
`else
  localparam bit BLINK_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        clr;
  logic [2:0]  req;
  logic [47:0] val;
  logic [2:0]  blink_req;
  logic [2:0]  grant;
  logic [15:0] x;
  logic        blank;
  logic        busy;

  int total = 0;
  int bad   = 0;

  // Reference model: owner index (-1 = nobody), cycles held, next-priority pointer.
  int          m_owner = -1;
  int          m_age   = 0;
  int          m_ptr   = 0;
  int          m_tick  = 0;
  logic [15:0] m_x     = 16'h0000;
  logic        m_blank = 1'b1;

  seg7_disp_sched #(
    .NREQ      (NREQ),
    .HOLD_CYC  (HOLD),
    .BLINK_DIV (BDIV)
  ) dut (
    .clk       (clk),
    .clr       (clr),
    .req       (req),
    .val       (val),
    .blink_req (blink_req),
    .grant     (grant),
    .x         (x),
    .blank     (blank),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic int pick(input logic [2:0] r, input int from, input int excl);
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = (from + k) % NREQ;
      if (r[idx] && idx != excl) return idx;
    end
    return -1;
  endfunction

  function automatic logic [20:0] exp_vec();
    logic [2:0] g;
    g = (m_owner < 0) ? 3'b000 : (3'b001 << m_owner);
    return {g, m_x, m_blank, (m_owner >= 0)};
  endfunction

  task automatic model_edge();
    int  j;
    int  nxt;
    logic ph;
    if (clr) begin
      m_owner = -1; m_age = 0; m_ptr = 0; m_tick = 0;
      m_x = 16'h0000; m_blank = 1'b1;
    end else begin
      ph = ((m_tick / BDIV) % 2) == 1;
      m_tick++;
      if (m_owner < 0) begin
        j = pick(req, m_ptr, -1);
        if (j >= 0) begin
          m_owner = j;
          m_age = 0;
        end
      end else begin
        m_x = val[m_owner*16 +: 16];
        m_blank = (BLINK_ON && blink_req[m_owner]) ? ph : 1'b0;
        if (m_age == HOLD - 1) begin
          nxt = (m_owner + 1) % NREQ;
          j = pick(req, nxt, m_owner);
          if (j >= 0) begin
            m_owner = j; m_age = 0; m_ptr = nxt;
          end else if (!req[m_owner]) begin
            m_owner = -1; m_age = 0; m_ptr = nxt; m_blank = 1'b1;
          end
        end else begin
          m_age++;
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    clr = 1'b1;
    req = 3'($urandom_range(0, 7));
    val = {$urandom(), $urandom()};
    blink_req = 3'($urandom_range(0, 7));
    for (int n = 0; n < 2; n++) begin
      step();
      total++;
      if ({grant, x, blank, busy} !== {3'b000, 16'h0000, 1'b1, 1'b0}) begin
        bad++;
        $display("FAIL reset n=%0d got g=%b x=%h bl=%b by=%b want g=000 x=0000 bl=1 by=0",
                 n, grant, x, blank, busy);
      end
    end
  endtask

  task automatic test_single();
    clr = 1'b0; req = 3'b001; blink_req = 3'b000;
    val = {$urandom(), 16'h1234};
    for (int n = 1; n <= 11; n++) begin
      if (n == 3) val[15:0] = 16'h1235;
      if (n == 4) req = 3'b000;
      step();
      total++;
      if ({grant, x, blank, busy} !== exp_vec()) begin
        bad++;
        $display("FAIL single n=%0d got %h want %h", n, {grant, x, blank, busy}, exp_vec());
      end
      if (n == 1) begin
        total++;
        if (grant !== 3'b001 || busy !== 1'b1) begin
          bad++;
          $display("FAIL single_grant got g=%b by=%b want 001 1", grant, busy);
        end
      end
      if (n == 2 || n == 3) begin
        total++;
        if (x !== ((n == 2) ? 16'h1234 : 16'h1235) || blank !== 1'b0) begin
          bad++;
          $display("FAIL single_x n=%0d got x=%h bl=%b want x=%h bl=0", n, x, blank,
                   (n == 2) ? 16'h1234 : 16'h1235);
        end
      end
    end
  endtask

  task automatic test_contention();
    logic [2:0] want;
    clr = 1'b1; step();
    clr = 1'b0; req = 3'b111; blink_req = 3'b000;
    val = {$urandom(), $urandom()};
    for (int n = 1; n <= 33; n++) begin
      step();
      want = 3'b001 << (((n - 1) / HOLD) % 3);
      total++;
      if (grant !== want || {grant, x, blank, busy} !== exp_vec()) begin
        bad++;
        $display("FAIL contention n=%0d got g=%b all=%h want g=%b all=%h",
                 n, grant, {grant, x, blank, busy}, want, exp_vec());
      end
    end
  endtask

  task automatic test_early_release();
    logic [2:0] want;
    clr = 1'b1; step();
    clr = 1'b0; req = 3'b010; blink_req = 3'b000;
    val = {$urandom(), $urandom()};
    for (int n = 1; n <= 10; n++) begin
      if (n == 4) req = 3'b000;
      step();
      want = (n <= HOLD) ? 3'b010 : 3'b000;
      total++;
      if (grant !== want || busy !== (n <= HOLD) || (n > HOLD && blank !== 1'b1)
          || {grant, x, blank, busy} !== exp_vec()) begin
        bad++;
        $display("FAIL early_release n=%0d got g=%b bl=%b by=%b want g=%b all=%h",
                 n, grant, blank, busy, want, exp_vec());
      end
    end
    req = 3'b011;
    step();
    total++;
    if (grant !== 3'b001 || {grant, x, blank, busy} !== exp_vec()) begin
      bad++;
      $display("FAIL ptr_wrap got g=%b want 001", grant);
    end
  endtask

  task automatic test_reset_mid();
    logic [2:0] want;
    clr = 1'b1; step();
    clr = 1'b0; req = 3'b100; blink_req = 3'b000;
    val = {$urandom(), $urandom()};
    for (int n = 1; n <= 5; n++) step();
    clr = 1'b1;
    step();
    total++;
    if ({grant, x, blank, busy} !== {3'b000, 16'h0000, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL reset_mid got g=%b x=%h bl=%b by=%b want 000 0000 1 0", grant, x, blank, busy);
    end
    clr = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      if (n == 2) req = 3'b110;
      step();
      want = (n <= HOLD) ? 3'b100 : 3'b010;
      total++;
      if (grant !== want || {grant, x, blank, busy} !== exp_vec()) begin
        bad++;
        $display("FAIL dwell_restart n=%0d got g=%b want g=%b", n, grant, want);
      end
    end
  endtask

  task automatic test_blink();
    logic want;
    clr = 1'b1; step();
    clr = 1'b0; req = 3'b001; blink_req = 3'b001;
    val = {$urandom(), $urandom()};
    for (int n = 1; n <= 20; n++) begin
      step();
      want = (n == 1) ? 1'b1 : (BLINK_ON ? (((n - 1) / BDIV) % 2 == 1) : 1'b0);
      total++;
      if (blank !== want || grant !== 3'b001 || {grant, x, blank, busy} !== exp_vec()) begin
        bad++;
        $display("FAIL blink n=%0d got bl=%b g=%b want bl=%b g=001", n, blank, grant, want);
      end
    end
  endtask

  task automatic test_random();
    clr = 1'b1; step();
    for (int n = 0; n < 600; n++) begin
      clr = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 3) == 0) req = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 7) == 0) blink_req = 3'($urandom_range(0, 7));
      val[16*$urandom_range(0, 2) +: 16] = 16'($urandom());
      step();
      total++;
      if ({grant, x, blank, busy} !== exp_vec()) begin
        bad++;
        $display("FAIL random n=%0d got %h want %h", n, {grant, x, blank, busy}, exp_vec());
      end
    end
  endtask

  initial begin
    clr = 1'b1; req = 3'b000; val = 48'h0; blink_req = 3'b000;
    test_reset();
    test_single();
    test_contention();
    test_early_release();
    test_reset_mid();
    test_blink();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
